// File: rtl/burst_responder.sv
// -----------------------------------------------------------------------------
// burst_responder
//
// Accepts a burst request (length + seed) and streams that many beats on a
// valid/ready output. The data of beat k is seed+k, wrapping modulo 2^DW.
// A length of 0 requests the maximum burst of 2^LW beats. The burst can be
// cancelled with abort. A normally completed burst raises a one-cycle done
// pulse alongside the handshake of its last beat.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : request offered by the initiator
//   req_ready  : responder is idle and can take a request
//   req_len    : beat count (0 means 2^LW)
//   req_seed   : data value of the first beat
//   abort      : synchronous burst cancel (ignored when idle)
//   dout_valid : beat valid (high throughout a burst)
//   dout_ready : downstream accepts the beat
//   dout_data  : beat data
//   dout_last  : current beat is the final beat of the burst
//   done       : one-cycle pulse on the final-beat handshake of a completed burst
//   busy       : a burst is in progress
// -----------------------------------------------------------------------------
module burst_responder #(
    parameter int DW = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [LW-1:0] req_len,
    input  logic [DW-1:0] req_seed,
    input  logic          abort,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout_data,
    output logic          dout_last,
    output logic          done,
    output logic          busy
);

    // One extra bit so a full burst of 2^LW beats fits in the length and
    // beat counters.
    localparam int CW = LW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] len_q,   len_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] data_q,  data_d;

    logic          beat_hs;
    logic          last_beat;

    assign last_beat = (cnt_q == len_q - CW'(1));

    // NOTE: every output and next-state signal gets its default before any
    // branch, so no path through this block leaves a value unassigned and
    // no latch is inferred.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        req_ready  = 1'b0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        beat_hs    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = BURST;
                    len_d   = (req_len == '0) ? {1'b1, {LW{1'b0}}}
                                              : {1'b0, req_len};
                    cnt_d   = '0;
                    data_d  = req_seed;
                end
            end

            BURST: begin
                busy       = 1'b1;
                dout_valid = 1'b1;
                dout_last  = last_beat;
                beat_hs    = dout_ready;

                // A handshaken beat always counts, even when abort arrives
                // in the same cycle.
                if (beat_hs) begin
                    cnt_d  = cnt_q + CW'(1);
                    data_d = data_q + DW'(1);
                end

                // Abort wins over completion: leave without a done pulse.
                if (abort) begin
                    state_d = IDLE;
                end else if (beat_hs && last_beat) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout_data = data_q;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule
